// File: rtl/sync_up_down_counter_param.sv
// Modulo-MODULUS up/down counter with parallel load, wrap/saturate limit
// handling, combinational terminal count, registered wrap pulse and sticky ovf.
module sync_up_down_counter_param #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             ud,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic at_max, at_zero;

  assign at_max  = (q == MAX);
  assign at_zero = (q == '0);
  // Same-cycle enable for a cascaded stage, so it must stay combinational.
  assign tc      = en & ~load & ((ud & at_max) | (~ud & at_zero));

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else if (load) begin
      q    <= (din > MAX) ? MAX : din;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else if (en) begin
      wrap <= 1'b0;
      if (ud) begin
        if (at_max) begin
          ovf <= 1'b1;
          if (!SATURATE) begin
            q    <= '0;
            wrap <= 1'b1;
          end
        end else begin
          q <= q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          ovf <= 1'b1;
          if (!SATURATE) begin
            q    <= MAX;
            wrap <= 1'b1;
          end
        end else begin
          q <= q - WIDTH'(1);
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_up_down_counter_param.sv
// Scoreboard bench for sync_up_down_counter_param: wrap, saturate, load clamp,
// async clear and a two-stage BCD cascade.
module tb_sync_up_down_counter_param;

  typedef struct {
    logic [3:0] q;
    logic       wrap;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb[$];

  // a: W3 M8 wrap
  logic a_clear = 1'b1, a_en = 1'b0, a_ud = 1'b0, a_load = 1'b0;
  logic [2:0] a_din = '0, a_q;
  logic a_tc, a_wrap, a_ovf;
  // b: W4 M10 saturate
  logic b_clear = 1'b1, b_en = 1'b0, b_ud = 1'b0, b_load = 1'b0;
  logic [3:0] b_din = '0, b_q;
  logic b_tc, b_wrap, b_ovf;
  // c: W4 M10 wrap
  logic c_clear = 1'b1, c_en = 1'b0, c_ud = 1'b0, c_load = 1'b0;
  logic [3:0] c_din = '0, c_q;
  logic c_tc, c_wrap, c_ovf;
  // k: two-stage cascade, M10 each
  logic k_clear = 1'b1, k_en = 1'b0, k_ud = 1'b1;
  logic [3:0] k_q0, k_q1;
  logic k_tc0, k_tc1, k_wrap0, k_wrap1, k_ovf0, k_ovf1;

  sync_up_down_counter_param #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) u_a (
    .clk(clk), .clear(a_clear), .en(a_en), .ud(a_ud), .load(a_load), .din(a_din),
    .q(a_q), .tc(a_tc), .wrap(a_wrap), .ovf(a_ovf));
  sync_up_down_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_b (
    .clk(clk), .clear(b_clear), .en(b_en), .ud(b_ud), .load(b_load), .din(b_din),
    .q(b_q), .tc(b_tc), .wrap(b_wrap), .ovf(b_ovf));
  sync_up_down_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_c (
    .clk(clk), .clear(c_clear), .en(c_en), .ud(c_ud), .load(c_load), .din(c_din),
    .q(c_q), .tc(c_tc), .wrap(c_wrap), .ovf(c_ovf));
  sync_up_down_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_k0 (
    .clk(clk), .clear(k_clear), .en(k_en), .ud(k_ud), .load(1'b0), .din(4'd0),
    .q(k_q0), .tc(k_tc0), .wrap(k_wrap0), .ovf(k_ovf0));
  sync_up_down_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_k1 (
    .clk(clk), .clear(k_clear), .en(k_tc0), .ud(k_ud), .load(1'b0), .din(4'd0),
    .q(k_q1), .tc(k_tc1), .wrap(k_wrap1), .ovf(k_ovf1));

  // Behavioural reference of one edge; mx is the top count (MODULUS-1).
  function automatic exp_t model(exp_t c, int mx, bit sat, logic en, logic ud,
                                 logic load, logic [3:0] din);
    exp_t n;
    n      = c;
    n.wrap = 1'b0;
    if (load) begin
      n.q   = (int'(din) > mx) ? 4'(mx) : din;
      n.ovf = 1'b0;
    end else if (en) begin
      if (ud) begin
        if (int'(c.q) == mx) begin
          n.ovf = 1'b1;
          if (!sat) begin n.q = 4'd0; n.wrap = 1'b1; end
        end else n.q = c.q + 4'd1;
      end else begin
        if (c.q == 4'd0) begin
          n.ovf = 1'b1;
          if (!sat) begin n.q = 4'(mx); n.wrap = 1'b1; end
        end else n.q = c.q - 4'd1;
      end
    end
    return n;
  endfunction

  task automatic test_reset;
    @(posedge clk); #1;
    n_chk++;
    if ({a_q, a_wrap, a_ovf, b_q, b_ovf, c_q, c_ovf, k_q0, k_q1} !== '0)
      $display("FAIL reset: a_q=%0d b_q=%0d c_q=%0d k=%0d%0d ovf=%b%b%b, want all 0",
               a_q, b_q, c_q, k_q1, k_q0, a_ovf, b_ovf, c_ovf);
    else n_pass++;
    a_clear = 0; b_clear = 0; c_clear = 0; k_clear = 0;
  endtask

  task automatic test_up_wrap;
    exp_t st, e;
    st = '{q: 4'd0, wrap: 1'b0, ovf: 1'b0};
    a_en = 1; a_ud = 1;
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (a_tc !== (st.q == 4'd7)) $display("FAIL up_tc[%0d]: got %b want %b", i, a_tc, st.q == 4'd7);
      else n_pass++;
      st = model(st, 7, 0, a_en, a_ud, a_load, {1'b0, a_din});
      sb.push_back(st);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if ({1'b0, a_q, a_wrap, a_ovf} !== {e.q, e.wrap, e.ovf})
        $display("FAIL up_wrap[%0d]: q/wrap/ovf=%0d/%b/%b want %0d/%b/%b", i, a_q, a_wrap, a_ovf, e.q, e.wrap, e.ovf);
      else n_pass++;
    end
    n_chk++;
    if (a_q !== 3'd2) $display("FAIL up_final: q=%0d want 2", a_q); else n_pass++;
    a_en = 0;
  endtask

  task automatic test_down_wrap;
    exp_t st, e;
    logic [2:0] want_q[5] = '{3'd7, 3'd6, 3'd5, 3'd5, 3'd5};
    a_load = 1; a_din = 3'd0;
    @(posedge clk); #1;
    a_load = 0;
    n_chk++;
    if ({a_q, a_ovf} !== 4'b0000) $display("FAIL load0: q=%0d ovf=%b want 0/0", a_q, a_ovf); else n_pass++;
    st = '{q: 4'd0, wrap: 1'b0, ovf: 1'b0};
    a_ud = 0;
    for (int i = 0; i < 5; i++) begin
      a_en = (i < 3);
      st = model(st, 7, 0, a_en, a_ud, 1'b0, 4'd0);
      sb.push_back(st);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if ({1'b0, a_q, a_wrap, a_ovf} !== {e.q, e.wrap, e.ovf} || a_q !== want_q[i])
        $display("FAIL down_wrap[%0d]: q/wrap/ovf=%0d/%b/%b want %0d/%b/%b", i, a_q, a_wrap, a_ovf, e.q, e.wrap, e.ovf);
      else n_pass++;
    end
    a_en = 0;
  endtask

  task automatic test_saturate;
    exp_t st, e;
    st = '{q: 4'd0, wrap: 1'b0, ovf: 1'b0};
    for (int i = 0; i < 7; i++) begin
      b_load = (i == 0 || i == 5);
      b_din  = (i == 0) ? 4'd8 : 4'd0;
      b_en   = !b_load;
      b_ud   = (i < 5);
      st = model(st, 9, 1, b_en, b_ud, b_load, b_din);
      sb.push_back(st);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if ({b_q, b_wrap, b_ovf} !== {e.q, e.wrap, e.ovf})
        $display("FAIL saturate[%0d]: q/wrap/ovf=%0d/%b/%b want %0d/%b/%b", i, b_q, b_wrap, b_ovf, e.q, e.wrap, e.ovf);
      else n_pass++;
    end
    b_en = 0; b_load = 0;
  endtask

  task automatic test_load;
    exp_t st, e;
    st = '{q: 4'd0, wrap: 1'b0, ovf: 1'b0};
    // load 9, up-wrap to 0, clamped load 13, then load beating en
    for (int i = 0; i < 4; i++) begin
      c_load = (i != 1);
      c_en   = (i != 2);
      c_ud   = 1;
      c_din  = (i == 0) ? 4'd9 : (i == 2) ? 4'd13 : 4'd3;
      if (i == 3) begin
        n_chk++;
        if (c_tc !== 1'b0) $display("FAIL load_tc: tc=%b want 0", c_tc); else n_pass++;
      end
      st = model(st, 9, 0, c_en, c_ud, c_load, c_din);
      sb.push_back(st);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if ({c_q, c_wrap, c_ovf} !== {e.q, e.wrap, e.ovf})
        $display("FAIL load[%0d]: q/wrap/ovf=%0d/%b/%b want %0d/%b/%b", i, c_q, c_wrap, c_ovf, e.q, e.wrap, e.ovf);
      else n_pass++;
    end
    c_load = 0; c_en = 0;
  endtask

  task automatic test_async_clear;
    a_load = 1; a_din = 3'd4;
    @(posedge clk); #1;
    a_load = 0; a_en = 1; a_ud = 1;
    @(posedge clk); #1;
    n_chk++;
    if (a_q !== 3'd5) $display("FAIL pre_clear: q=%0d want 5", a_q); else n_pass++;
    #3 a_clear = 1;
    #1;
    n_chk++;
    if ({a_q, a_wrap, a_ovf} !== 5'b0) $display("FAIL async_clear: q=%0d wrap=%b ovf=%b want 0", a_q, a_wrap, a_ovf);
    else n_pass++;
    #1 a_clear = 0;
    @(posedge clk); #1;
    n_chk++;
    if (a_q !== 3'd1) $display("FAIL post_clear: q=%0d want 1", a_q); else n_pass++;
    a_en = 0;
  endtask

  task automatic test_cascade;
    exp_t e;
    int cnt = 0;
    k_en = 1;
    for (int i = 0; i < 32; i++) begin
      k_ud = (i < 25);
      cnt = k_ud ? (cnt + 1) % 100 : (cnt + 99) % 100;
      sb.push_back('{q: 4'(cnt % 10), wrap: 1'b0, ovf: 1'b0});
      sb.push_back('{q: 4'(cnt / 10), wrap: 1'b0, ovf: 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if (k_q0 !== e.q) $display("FAIL cascade_q0[%0d]: got %0d want %0d", i, k_q0, e.q); else n_pass++;
      e = sb.pop_front();
      n_chk++;
      if (k_q1 !== e.q) $display("FAIL cascade_q1[%0d]: got %0d want %0d", i, k_q1, e.q); else n_pass++;
      if (i == 24) begin
        n_chk++;
        if ({k_q1, k_q0} !== 8'h25) $display("FAIL cascade_bcd25: got %h want 25", {k_q1, k_q0});
        else n_pass++;
      end
    end
    n_chk++;
    if ({k_q1, k_q0} !== 8'h18) $display("FAIL cascade_bcd18: got %h want 18", {k_q1, k_q0});
    else n_pass++;
    n_chk++;
    if (k_tc1 !== 1'b0) $display("FAIL cascade_tc1: got %b want 0", k_tc1); else n_pass++;
    k_en = 0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_load();
    test_async_clear();
    test_cascade();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
